// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
//
// Instruction memory with a single-entry fetch pipeline.
// - A fetch request (req_valid/req_ready) is answered one cycle later on the
//   rsp_valid/rsp_ready channel.
// - The response carries the instruction word together with two fault flags.
// - Program words are written through a dedicated load port. A load blocks
//   fetch acceptance for that cycle.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : fetch request present
//   req_ready  : request accepted this cycle (combinational)
//   req_pc     : fetch byte address (ADDR_W bits)
//   rsp_valid  : response present
//   rsp_ready  : consumer accepts the response
//   rsp_instr  : fetched instruction word, zero when the response is faulted
//   rsp_fault  : bit0 = misaligned PC, bit1 = PC beyond the memory
//   ld_en      : program-load write strobe
//   ld_idx     : program-load word index
//   ld_data    : program-load word
//   fault_cnt  : saturating count of faulted response handshakes
// -----------------------------------------------------------------------------
module imem_fetch_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [1:0]        rsp_fault,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    output logic [15:0]       fault_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,   // no response held
        ST_RESP = 1'b1    // response held on the rsp channel
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rsp_instr;
    logic [1:0]        r_rsp_fault;
    logic [15:0]       r_fault_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic [1:0]        w_fault;
    logic              w_accept;
    logic              w_rsp_hs;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    assign w_idx          = req_pc[IDX_W+1:2];
    assign w_misaligned   = |req_pc[1:0];
    // Any bit above the index range flags the PC as out of range, so high
    // addresses never alias onto a low word.
    assign w_out_of_range = |req_pc[ADDR_W-1:IDX_W+2];
    assign w_fault        = {w_out_of_range, w_misaligned};

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    // A held response frees the slot in the same cycle it is consumed. This
    // gives one fetch per cycle when rsp_ready stays high. A load cycle and
    // reset both block acceptance.
    assign req_ready = rst_n && !ld_en && ((r_state == ST_IDLE) || rsp_ready);
    assign w_accept  = req_valid && req_ready;
    assign w_rsp_hs  = (r_state == ST_RESP) && rsp_ready;

    // ------------------------------------------------------------------------
    // Program memory
    // ------------------------------------------------------------------------
    // NOTE: the storage array has no reset branch. Program contents must
    //       survive reset, and a reset port on a RAM array blocks inference
    //       as a memory macro.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_idx] <= ld_data;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking assignments only. Every register
    //       then samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment at the top covers every path, so this
    //       block cannot infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // An acceptance refills the slot being drained, so only a
                // handshake without a new request empties it.
                if (w_rsp_hs && !w_accept) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------------
    // The register loads only on acceptance, so a stalled response stays
    // stable. Acceptance and load never coincide, which means the read always
    // sees a load written at an earlier edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_instr <= '0;
            r_rsp_fault <= '0;
        end else if (w_accept) begin
            r_rsp_fault <= w_fault;
            r_rsp_instr <= (w_fault != 2'b00) ? '0 : r_mem[w_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Fault counter: counts consumed faulted responses, saturates at all ones
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault_cnt <= '0;
        end else if (w_rsp_hs && (r_rsp_fault != 2'b00) && (r_fault_cnt != 16'hFFFF)) begin
            r_fault_cnt <= r_fault_cnt + 16'd1;
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_instr = r_rsp_instr;
    assign rsp_fault = r_rsp_fault;
    assign fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_unit
//
// Self-checking bench for imem_fetch_unit.
// - Directed scenarios: load/fetch, backpressure, faults, load collision,
//   reset mid-operation and counter saturation.
// - Randomized traffic phase.
// Every cycle is checked against a behavioural model that works from byte
// addresses, a valid flag and an array image of the program.
// -----------------------------------------------------------------------------
module tb_imem_fetch_unit;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;
    localparam int IDX_W  = 9;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [1:0]        rsp_fault;
    logic              ld_en;
    logic [IDX_W-1:0]  ld_idx;
    logic [DATA_W-1:0] ld_data;
    logic [15:0]       fault_cnt;

    imem_fetch_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .fault_cnt (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] mem_m [DEPTH];
    logic              m_valid;
    logic [DATA_W-1:0] m_instr;
    logic [1:0]        m_fault;
    int                m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected response for a byte address: alignment and range come from
    // plain arithmetic on the address.
    function automatic void model_fetch(input logic [63:0] pc,
                                        output logic [DATA_W-1:0] instr,
                                        output logic [1:0] fault);
        fault[0] = (pc % 64'd4) != 64'd0;
        fault[1] = pc >= 64'(DEPTH * 4);
        if (fault != 2'b00) instr = '0;
        else                instr = mem_m[int'(pc / 64'd4)];
    endfunction

    // One clock cycle.
    // - Drive the inputs and check the combinational ready.
    // - Clock the DUT and advance the model.
    // - Check the registered outputs.
    task automatic cycle(input logic rn, input logic rv, input logic [63:0] pc,
                         input logic rr, input logic le, input logic [IDX_W-1:0] li,
                         input logic [DATA_W-1:0] ld);
        logic exp_ready;
        logic accept;
        logic hs;
        rst_n     = rn;
        req_valid = rv;
        req_pc    = pc;
        rsp_ready = rr;
        ld_en     = le;
        ld_idx    = li;
        ld_data   = ld;
        #1;
        exp_ready = rn && !le && (!m_valid || rr);
        accept    = rv && exp_ready;
        hs        = m_valid && rr;
        check("req_ready", req_ready, exp_ready);
        @(posedge clk);
        #1;
        if (!rn) begin
            m_valid = 1'b0;
            m_instr = '0;
            m_fault = '0;
            m_cnt   = 0;
        end else begin
            if (hs && m_fault != 2'b00 && m_cnt < 65535) m_cnt++;
            if (accept) begin
                m_valid = 1'b1;
                model_fetch(pc, m_instr, m_fault);
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
        if (le) mem_m[li] = ld;
        check("rsp_valid", rsp_valid, m_valid);
        check("fault_cnt", fault_cnt, 64'(m_cnt));
        if (m_valid) begin
            check("rsp_instr", rsp_instr, m_instr);
            check("rsp_fault", rsp_fault, m_fault);
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b1, 1'b0, 64'd0, rr, 1'b0, '0, '0);
    endtask

    task automatic fetch(input logic [63:0] pc, input logic rr);
        cycle(1'b1, 1'b1, pc, rr, 1'b0, '0, '0);
    endtask

    task automatic load(input logic [IDX_W-1:0] li, input logic [DATA_W-1:0] ld);
        cycle(1'b1, 1'b0, 64'd0, 1'b0, 1'b1, li, ld);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] pc;
        case ($urandom_range(0, 5))
            0, 1, 2: pc = 64'($urandom_range(0, DEPTH - 1)) << 2;
            3:       pc = (64'($urandom_range(0, DEPTH - 1)) << 2) | 64'($urandom_range(1, 3));
            4: begin
                pc = {$urandom(), $urandom()};
                if (pc < 64'(DEPTH * 4)) pc = pc | 64'(DEPTH * 4);
            end
            default: begin
                case ($urandom_range(0, 3))
                    0:       pc = 64'(DEPTH * 4 - 4);
                    1:       pc = 64'(DEPTH * 4);
                    2:       pc = 64'hFFFF_FFFF_FFFF_FFFC;
                    default: pc = 64'h1_0000_0000;
                endcase
            end
        endcase
        return pc;
    endfunction

    logic [DATA_W-1:0] prog [4];

    initial begin
        m_valid = 1'b0;
        m_instr = '0;
        m_fault = '0;
        m_cnt   = 0;
        prog[0] = 32'hF84002A0;
        prog[1] = 32'hF84002A1;
        prog[2] = 32'hF80002A0;
        prog[3] = 32'hF80002A1;

        // Reset state
        do_reset();
        do_reset();
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_instr", rsp_instr, 32'd0);
        check("rst_fault", rsp_fault, 2'd0);
        check("rst_cnt",   fault_cnt, 16'd0);

        // Load then fetch: four back-to-back responses
        for (int i = 0; i < 4; i++) load(IDX_W'(i), prog[i]);
        for (int i = 0; i < 4; i++) begin
            fetch(64'(i * 4), 1'b1);
            check("lf_valid", rsp_valid, 1'b1);
            check("lf_instr", rsp_instr, prog[i]);
            check("lf_fault", rsp_fault, 2'd0);
        end
        idle(1'b1);
        check("lf_drain", rsp_valid, 1'b0);

        // Backpressure
        fetch(64'h4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_pc    = 64'h8;
            #1;
            check("bp_ready", req_ready, 1'b0);
            fetch(64'h8, 1'b0);
            check("bp_instr", rsp_instr, 32'hF84002A1);
        end
        fetch(64'h8, 1'b1);
        check("bp_next", rsp_instr, 32'hF80002A0);
        idle(1'b1);

        // Faults
        fetch(64'h6, 1'b1);
        check("f_mis_fault", rsp_fault, 2'b01);
        check("f_mis_instr", rsp_instr, 32'd0);
        fetch(64'h800, 1'b1);
        check("f_oor_fault", rsp_fault, 2'b10);
        fetch(64'h802, 1'b1);
        check("f_both_fault", rsp_fault, 2'b11);
        check("f_both_instr", rsp_instr, 32'd0);
        idle(1'b1);
        check("f_cnt3", fault_cnt, 16'd3);

        // Load collision: the request waits for the load cycle to pass
        cycle(1'b1, 1'b1, 64'h14, 1'b1, 1'b1, 9'd5, 32'hDEADBEEF);
        check("col_blocked", rsp_valid, 1'b0);
        fetch(64'h14, 1'b0);
        check("col_instr", rsp_instr, 32'hDEADBEEF);

        // Reset mid-operation, with the response held
        idle(1'b0);
        check("mr_held", rsp_valid, 1'b1);
        do_reset();
        check("mr_valid", rsp_valid, 1'b0);
        check("mr_cnt",   fault_cnt, 16'd0);
        idle(1'b1);
        check("mr_noreissue", rsp_valid, 1'b0);
        fetch(64'h14, 1'b1);
        check("mr_mem", rsp_instr, 32'hDEADBEEF);
        idle(1'b1);

        // Randomized traffic after a full program image is loaded
        for (int i = 0; i < DEPTH; i++) load(IDX_W'(i), $urandom());
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) != 0),
                  1'($urandom_range(0, 1)),
                  rand_pc(),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0),
                  IDX_W'($urandom_range(0, DEPTH - 1)),
                  $urandom());
        end

        // Saturation of the fault counter
        do_reset();
        for (int i = 0; i < 65540; i++) fetch(64'h6, 1'b1);
        idle(1'b1);
        check("sat_cnt", fault_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
